adsr_envelope_gain: RTL and testbench



---
 rtl/synth_pkg.sv | 26 ++
 rtl/env_gain_pipe.sv | 77 +++++++
 rtl/adsr_envelope_gain.sv | 145 ++++++++++++++
 tb/tb_adsr_envelope_gain.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : synth_pkg
//  Purpose  : Types and constants shared by the voice datapath (sample
//             player, envelope/gain stage, mixer).
//  Contents : env_state_t - ADSR state encoding (3 bits)
//             ENV_MAX     - full-scale envelope level
//             sample_t    - 16-bit signed audio sample
//  Revision : 1.0 - initial release
// ============================================================================
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] ENV_MAX = 16'hFFFF;

    typedef logic signed [15:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/env_gain_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : env_gain_pipe
//  Purpose  : Three-register gain pipeline. Captures a sample and an envelope
//             level on the capture strobe, multiplies them on the next edge
//             and registers the scaled result with a one-cycle valid pulse
//             on the edge after that.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             i_capture        - capture strobe (one cycle per sample period)
//             i_sample         - signed input sample
//             i_sample_valid   - when low the captured sample is forced to 0
//             i_level          - unsigned envelope level (0x0000..0xFFFF)
//             o_sample         - signed (sample * level) >>> 16
//             o_valid          - one-cycle pulse, 2 clocks after capture
//  Revision : 1.0 - initial release
// ============================================================================
module env_gain_pipe
    import synth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_capture,
    input  sample_t     i_sample,
    input  logic        i_sample_valid,
    input  logic [15:0] i_level,
    output sample_t     o_sample,
    output logic        o_valid
);

    sample_t            r_s1_sample;
    logic [15:0]        r_s1_level;
    logic               r_s1_vld;
    sample_t            r_s2_scaled;
    logic               r_s2_vld;
    sample_t            r_out;
    logic               r_out_vld;

    // Signed 16 x unsigned 16 has magnitude below 2^31, so a 32-bit signed
    // product is exact; the level is zero-extended to keep it non-negative.
    logic signed [31:0] w_prod;
    logic               w_unused_prod;

    assign w_prod        = $signed({{16{r_s1_sample[15]}}, r_s1_sample})
                         * $signed({16'd0, r_s1_level});
    // Bits below the binary point are dropped by the floor shift.
    assign w_unused_prod = ^w_prod[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sample <= '0;
            r_s1_level  <= '0;
            r_s1_vld    <= 1'b0;
            r_s2_scaled <= '0;
            r_s2_vld    <= 1'b0;
            r_out       <= '0;
            r_out_vld   <= 1'b0;
        end else begin
            r_s1_vld <= i_capture;
            if (i_capture) begin
                r_s1_sample <= i_sample_valid ? i_sample : sample_t'(0);
                r_s1_level  <= i_level;
            end
            // Taking bits [31:16] is the arithmetic >>> 16 (floor).
            r_s2_vld    <= r_s1_vld;
            r_s2_scaled <= w_prod[31:16];
            r_out_vld   <= r_s2_vld;
            if (r_s2_vld) begin
                r_out <= r_s2_scaled;
            end
        end
    end

    assign o_sample = r_out;
    assign o_valid  = r_out_vld;

endmodule
`default_nettype wire

// File: rtl/adsr_envelope_gain.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_envelope_gain
//  Purpose  : Per-voice ADSR amplitude envelope and gain stage. Updates a
//             16-bit envelope once per audio sample period and scales the
//             player sample by it, emitting one sample per period.
//  Ports    : mclk, rst        - master clock, synchronous active-high reset
//             gate             - note on (1) / note off (0), sampled at ticks
//             attack_step      - level increment per tick in ATTACK
//             decay_step       - level decrement per tick in DECAY
//             sustain_level    - SUSTAIN level (tracked live)
//             release_step     - level decrement per tick in RELEASE
//             sample_in(_valid)- signed player sample and its qualifier
//             sample_out(_valid)- scaled sample, one pulse per period
//             env_level        - current envelope level
//             env_state        - current state (IDLE..RELEASE)
//             busy             - env_state != IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module adsr_envelope_gain
    import synth_pkg::*;
#(
    parameter int MCLK_PER_SAMPLE = 256,
    parameter int LEVEL_BITS      = 16
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  gate,
    input  logic [LEVEL_BITS-1:0] attack_step,
    input  logic [LEVEL_BITS-1:0] decay_step,
    input  logic [LEVEL_BITS-1:0] sustain_level,
    input  logic [LEVEL_BITS-1:0] release_step,
    input  sample_t               sample_in,
    input  logic                  sample_in_valid,
    output sample_t               sample_out,
    output logic                  sample_out_valid,
    output logic [LEVEL_BITS-1:0] env_level,
    output logic [2:0]            env_state,
    output logic                  busy
);

    localparam int                CNT_W    = $clog2(MCLK_PER_SAMPLE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MCLK_PER_SAMPLE - 1);

    logic [CNT_W-1:0] r_div;
    logic             w_tick;
    logic             r_gate_prev;
    logic             w_rise;
    logic             w_fall;
    env_state_t       r_state;
    env_state_t       w_state_nxt;
    logic [15:0]      r_level;
    logic [15:0]      w_level_nxt;
    logic [16:0]      w_att_sum;
    logic [16:0]      w_dec_diff;

    assign w_tick = (r_div == CNT_LAST);
    assign w_rise = gate & ~r_gate_prev;
    assign w_fall = ~gate & r_gate_prev;

    // 17-bit arithmetic: bit 16 flags attack overflow / decay underflow.
    assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_step};
    assign w_dec_diff = {1'b0, r_level} - {1'b0, decay_step};

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_div       <= '0;
            r_gate_prev <= 1'b0;
            r_state     <= IDLE;
            r_level     <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + CNT_W'(1);
            if (w_tick) begin
                r_gate_prev <= gate;
                r_state     <= w_state_nxt;
                r_level     <= w_level_nxt;
            end
        end
    end

    // Gate edges only move the state; the level is kept so a retrigger
    // ramps from wherever the envelope currently is (no click).
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (w_rise) begin
            w_state_nxt = ATTACK;
        end else if (w_fall && (r_state == ATTACK || r_state == DECAY ||
                                r_state == SUSTAIN)) begin
            w_state_nxt = RELEASE;
        end else begin
            case (r_state)
                ATTACK: begin
                    if (w_att_sum[16] || (w_att_sum[15:0] == ENV_MAX)) begin
                        w_level_nxt = ENV_MAX;
                        w_state_nxt = DECAY;
                    end else begin
                        w_level_nxt = w_att_sum[15:0];
                    end
                end
                DECAY: begin
                    if (w_dec_diff[16] || (w_dec_diff[15:0] <= sustain_level)) begin
                        w_level_nxt = sustain_level;
                        w_state_nxt = SUSTAIN;
                    end else begin
                        w_level_nxt = w_dec_diff[15:0];
                    end
                end
                SUSTAIN: begin
                    w_level_nxt = sustain_level;
                end
                RELEASE: begin
                    if (r_level > release_step) begin
                        w_level_nxt = r_level - release_step;
                    end else begin
                        w_level_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_level_nxt = '0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // The pipe captures the pre-update level on the same tick edge.
    env_gain_pipe u_gain_pipe (
        .clk            (mclk),
        .rst            (rst),
        .i_capture      (w_tick),
        .i_sample       (sample_in),
        .i_sample_valid (sample_in_valid),
        .i_level        (r_level),
        .o_sample       (sample_out),
        .o_valid        (sample_out_valid)
    );

    assign env_level = r_level;
    assign env_state = r_state;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope_gain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_envelope_gain
//  Purpose  : Self-checking bench for adsr_envelope_gain (MCLK_PER_SAMPLE=4).
//             A behavioural envelope/gain model is compared against the DUT
//             every cycle; directed literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope_gain;

    localparam int N = 4;

    logic        mclk = 1'b0;
    logic        rst;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        busy;

    int total = 0;
    int bad   = 0;

    adsr_envelope_gain #(.MCLK_PER_SAMPLE(N), .LEVEL_BITS(16)) dut (
        .mclk             (mclk),
        .rst              (rst),
        .gate             (gate),
        .attack_step      (attack_step),
        .decay_step       (decay_step),
        .sustain_level    (sustain_level),
        .release_step     (release_step),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .env_level        (env_level),
        .env_state        (env_state),
        .busy             (busy)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int val; } pend_t;
    pend_t pend[$];
    int cyc = 0;
    int m_cnt = 0;
    int m_lvl = 0;
    int m_st = 0;
    bit m_gprev = 1'b0;
    bit m_last_tick = 1'b0;
    int e_out = 0;
    bit e_vld = 1'b0;

    function automatic int gain(input int s, input int l);
        longint p;
        p = longint'(s) * longint'(l);
        return int'(p >>> 16);
    endfunction

    always @(posedge mclk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            m_cnt = 0; m_lvl = 0; m_st = 0; m_gprev = 1'b0;
            m_last_tick = 1'b0; e_out = 0; e_vld = 1'b0;
        end else begin
            e_vld = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_out = pend[0].val;
                e_vld = 1'b1;
                void'(pend.pop_front());
            end
            m_last_tick = (m_cnt == N - 1);
            if (m_last_tick) begin
                pend.push_back('{cyc + 2,
                    gain(sample_in_valid ? int'($signed(sample_in)) : 0, m_lvl)});
                if (gate && !m_gprev) begin
                    m_st = 1;
                end else if (!gate && m_gprev && m_st >= 1 && m_st <= 3) begin
                    m_st = 4;
                end else begin
                    case (m_st)
                        1: begin
                            m_lvl = m_lvl + int'(attack_step);
                            if (m_lvl >= 65535) begin m_lvl = 65535; m_st = 2; end
                        end
                        2: begin
                            m_lvl = m_lvl - int'(decay_step);
                            if (m_lvl <= int'(sustain_level)) begin
                                m_lvl = int'(sustain_level); m_st = 3;
                            end
                        end
                        3: m_lvl = int'(sustain_level);
                        4: begin
                            m_lvl = m_lvl - int'(release_step);
                            if (m_lvl <= 0) begin m_lvl = 0; m_st = 0; end
                        end
                        default: m_lvl = 0;
                    endcase
                end
                m_gprev = gate;
            end
            m_cnt = (m_cnt + 1) % N;
        end
    end

    always @(negedge mclk) begin
        chk("cyc_sample_out", int'($signed(sample_out)), e_out);
        chk("cyc_valid", int'(sample_out_valid), int'(e_vld));
        chk("cyc_level", int'(env_level), m_lvl);
        chk("cyc_state", int'(env_state), m_st);
        chk("cyc_busy", int'(busy), int'(m_st != 0));
    end

    // ---------------- directed stimulus ----------------
    task automatic after_tick();
        int n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!m_last_tick && n < 2 * N);
        if (!m_last_tick) begin
            total++; bad++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", n);
        end
    endtask

    task automatic tick_chk(input string nm, input int lvl, input int st);
        after_tick();
        chk({nm, "_level"}, int'(env_level), lvl);
        chk({nm, "_state"}, int'(env_state), st);
    endtask

    task automatic gain_chk(input string nm, input int s, input bit v, input int exp);
        sample_in = s[15:0];
        sample_in_valid = v;
        after_tick();
        repeat (2) @(negedge mclk);
        chk({nm, "_valid"}, int'(sample_out_valid), 1);
        chk(nm, int'($signed(sample_out)), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst = 1'b1; gate = 1'b1;
        attack_step = 16'h4000; decay_step = 16'h1000;
        sustain_level = 16'hC000; release_step = 16'h8000;
        sample_in = 16'd16384; sample_in_valid = 1'b1;
        repeat (3) @(negedge mclk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_out_valid), 0);
        chk("rst_state", int'(env_state), 0);
        chk("rst_level", int'(env_level), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // attack ramp
        tick_chk("t1_rise", 0, 1);
        tick_chk("t2", 16'h4000, 1);
        tick_chk("t3", 16'h8000, 1);
        gain_chk("gain_lvl8000", 16384, 1'b1, 8192);
        chk("t4_level", int'(env_level), 16'hC000);
        tick_chk("t5_peak", 16'hFFFF, 2);
        // decay to sustain
        tick_chk("t6", 16'hEFFF, 2);
        tick_chk("t7", 16'hDFFF, 2);
        tick_chk("t8", 16'hCFFF, 2);
        tick_chk("t9_sus", 16'hC000, 3);
        sustain_level = 16'hA000;
        tick_chk("t10_sus_live", 16'hA000, 3);
        sustain_level = 16'hC000;
        tick_chk("t11_sus", 16'hC000, 3);
        // release to idle
        gate = 1'b0;
        tick_chk("t12_fall", 16'hC000, 4);
        tick_chk("t13_rel", 16'h4000, 4);
        tick_chk("t14_idle", 0, 0);
        chk("t14_busy", int'(busy), 0);
        // second note, retrigger during release
        gate = 1'b1;
        tick_chk("t15_rise", 0, 1);
        repeat (4) after_tick();
        chk("t19_peak", int'(env_level), 16'hFFFF);
        repeat (4) after_tick();
        chk("t23_sus", int'(env_state), 3);
        gate = 1'b0;
        tick_chk("t24_fall", 16'hC000, 4);
        tick_chk("t25_rel", 16'h4000, 4);
        gate = 1'b1;
        tick_chk("t26_regate", 16'h4000, 1);
        tick_chk("t27_ramp", 16'h8000, 1);
        // gain corners at 0x8000 (held by a zero attack step)
        attack_step = 16'h0000;
        gain_chk("gain_1000", 1000, 1'b1, 500);
        gain_chk("gain_m1", -1, 1'b1, -1);
        gain_chk("gain_invalid", 1234, 1'b0, 0);
        chk("hold_level", int'(env_level), 16'h8000);
        sample_in_valid = 1'b1;
        attack_step = 16'h8000;
        tick_chk("t31_clamp", 16'hFFFF, 2);
        // gain corners at 0xFFFF (held by a zero decay step)
        decay_step = 16'h0000;
        gain_chk("gain_max", 32767, 1'b1, 32766);
        gain_chk("gain_min", -32768, 1'b1, -32768);
        decay_step = 16'h1000;
        // reset one cycle after a tick in ATTACK
        gate = 1'b0;
        after_tick();
        gate = 1'b1;
        tick_chk("pre_rst_attack", 16'hFFFF, 1);
        rst = 1'b1;
        @(negedge mclk);
        chk("mid_rst_level", int'(env_level), 0);
        chk("mid_rst_state", int'(env_state), 0);
        chk("mid_rst_sample_out", int'(sample_out), 0);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge mclk);
            if (sample_out_valid) pulses++;
        end
        chk("mid_rst_no_pulse", pulses, 0);
        repeat (3) after_tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
